clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Programmable, glitch-free clock-divider controller for the floating-point DSP processor. It generates a divided clock and a per-period tick strobe from the 100 MHz system clock for the slower datapath stages. The divide ratio is reconfigured at run time through a valid/ready handshake. A new ratio takes effect only at a period boundary, and stopping never produces a runt pulse.

## Interface

**Parameters**
- `CNT_W`, 16: width of the half-period count and of the counter.
- `DEF_HALF`, 5: half-period, in `clk_in` cycles, loaded at reset (5 gives 10 MHz from 100 MHz).

**Ports**
- `clk_in`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: synchronous, active-low reset, sampled on the `clk_in` rising edge.
- `run`, in, 1: level enable for the divider.
- `cfg_valid`, in, 1: new half-period request.
- `cfg_half`, in, CNT_W: requested half-period H. Output period is 2H `clk_in` cycles.
- `cfg_ready`, out, 1: request accepted on an edge where `cfg_valid && cfg_ready`.
- `clk_out`, out, 1: divided clock, registered.
- `tick`, out, 1: one-cycle pulse, high exactly on the cycles where `clk_out` has just risen.
- `active_half`, out, CNT_W: half-period currently in use.
- `busy`, out, 1: a change is pending, waiting for the boundary.
- `cfg_err`, out, 1: one-cycle pulse when a request with `cfg_half == 0` is accepted.

## Operation

**Reset values**
- `state` = STOP, `cnt` = 0, `clk_out` = 0, `tick` = 0.
- `active_half` = DEF_HALF, `pending` = 0.
- `busy` = 0, `cfg_err` = 0, `cfg_ready` = 1.
- Reset mid-operation returns all of these values on the next edge and discards any pending request.

**States**
- STOP
  - `clk_out` held 0, `cnt` held 0, `cfg_ready` = 1.
  - An accepted, nonzero `cfg_half` loads `active_half` directly.
  - `run` = 1 goes to RUN with `cnt` = 0.
- RUN
  - Each edge: if `cnt == active_half-1`, then `cnt` <= 0 and `clk_out` toggles. Otherwise `cnt`++.
  - An accepted, nonzero request stores `pending` and goes to PEND.
- PEND
  - `cfg_ready` = 0, `busy` = 1.
  - Counting continues with the old `active_half`.
  - On the toggle that drives `clk_out` 0 to 1, `active_half` <= `pending`, `cnt` <= 0, and the state returns to RUN. The new high phase uses the new H.

**Stopping**
- If `run` is 0 while in RUN or PEND and `clk_out` = 0: go to STOP on that edge. The output is already low, so no pulse is produced.
- If `clk_out` = 1: keep counting until the falling toggle, then go to STOP. The high phase is never truncated.
- Stopping from PEND loads `pending` into `active_half` on entry to STOP.
- `run` reasserted during the completion of the high phase is ignored until STOP is reached.

**Zero request**
- `cfg_half == 0` is still accepted (handshake completes).
- `cfg_err` pulses for one cycle, the value is discarded, and state is unchanged.

**Simultaneous request and rising toggle in RUN**
- The toggle uses the old H.
- The request goes to PEND and applies at the next 0 to 1 boundary, a full period later.

**Derived outputs**
- `cfg_ready` = (state != PEND), decoded from state only, with no path from `cfg_valid`.
- `tick` is registered together with `clk_out`: `tick` = 1 iff this edge set `clk_out` from 0 to 1.

## Timing

- `run` sampled high at edge k in STOP: `clk_out` rises at edge k+H, falls at k+2H, then repeats with period 2H and 50% duty.
- H = 1 gives `clk_in`/2, toggling every edge.
- Handshake to effect:
  - Request accepted at edge a: `cfg_ready` = 0 and `busy` = 1 from edge a.
  - The new H is visible on `active_half` at the first rising toggle after a.
  - `cfg_ready` returns to 1 on that same edge.
- No `clk_out` phase (high or low) is ever shorter than min(old H, new H).
- `cnt` never exceeds `active_half`-1, and it wraps to 0 on every toggle.

## Test plan

- **Reset and default:** hold `rst` = 0 for 2 cycles, release, then `run` = 1 at edge k. Expect `clk_out` rising at k+5, k+15, k+25 (period 10, duty 5/5), `tick` high exactly on those cycles, and `active_half` = 5.
- **Reconfigure while running:** H = 5, send `cfg_half` = 2 during the high phase. Expect `cfg_ready` = 0 and `busy` = 1; the current period finishes at 10 cycles, then periods are 4 cycles. `cfg_ready` = 1 and `active_half` = 2 at the boundary edge.
- **Clean stop:** H = 5, drop `run` with 3 high cycles remaining. Expect the high phase to last the full 5 cycles, then `clk_out` held 0 and `tick` = 0. Drop `run` during the low phase: expect STOP immediately with no additional rise.
- **Zero request:** `cfg_half` = 0 with `cfg_valid` = 1. Expect the handshake to complete, a one-cycle `cfg_err` pulse, `active_half` unchanged, and the period unchanged.
- **Minimum ratio:** `cfg_half` = 1 in STOP, then `run` = 1. Expect `clk_out` to toggle every edge and `tick` every 2 cycles.
- **Reset mid-PEND:** with a pending `cfg_half` = 8, assert `rst` = 0 for 1 cycle. Expect all reset values, `active_half` = 5, and after `run` the period is 10, not 16.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Programmable, glitch-free clock divider controller. Produces a divided clock
// (period 2*H clk_in cycles, 50% duty) and a tick strobe on every rising edge
// of that clock. The half-period H is changed at run time through a valid/ready
// handshake and only takes effect at a rising boundary of clk_out. Stopping
// always lets a started high phase finish, so no runt pulse is ever emitted.
//
// Ports
//   clk_in      in   system clock (single domain)
//   rst         in   synchronous active-low reset
//   run         in   level enable
//   cfg_valid   in   half-period change request
//   cfg_half    in   requested half-period H (0 is rejected with cfg_err)
//   cfg_ready   out  request accepted when cfg_valid && cfg_ready
//   clk_out     out  divided clock, registered
//   tick        out  one-cycle pulse on the cycle clk_out has just risen
//   active_half out  half-period currently in use
//   busy        out  a change is pending, waiting for the rising boundary
//   cfg_err     out  one-cycle pulse when a zero request is accepted
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEF_HALF = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] active_half,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_half_q, active_half_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             busy_q;
    logic             ready_q;
    logic             err_q, err_d;
    logic             stop_req_q, stop_req_d;

    logic             accept_c;
    logic             accept_ok_c;
    logic             wrap_c;

    // Handshake decode; ready_q is a pure function of the registered state.
    assign accept_c    = cfg_valid && ready_q;
    assign accept_ok_c = accept_c && (cfg_half != '0);
    // active_half is never zero, so the subtraction cannot underflow.
    assign wrap_c      = (cnt_q == (active_half_q - CNT_W'(1)));

    // Next-state and next-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        clk_out_d     = clk_out_q;
        tick_d        = 1'b0;
        active_half_d = active_half_q;
        pending_d     = pending_q;
        stop_req_d    = stop_req_q;
        err_d         = accept_c && (cfg_half == '0);

        case (state_q)
            ST_STOP: begin
                cnt_d      = '0;
                clk_out_d  = 1'b0;
                stop_req_d = 1'b0;
                if (accept_ok_c) begin
                    active_half_d = cfg_half;
                end
                if (run) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_PEND: begin
                if (!run && !clk_out_q) begin
                    // Output already low: stop right away, nothing is cut short.
                    state_d    = ST_STOP;
                    cnt_d      = '0;
                    stop_req_d = 1'b0;
                    if (state_q == ST_PEND) begin
                        active_half_d = pending_q;
                    end else if (accept_ok_c) begin
                        active_half_d = cfg_half;
                    end
                end else begin
                    // Dropping run in the high phase is remembered so that a
                    // re-assertion cannot cancel the stop at the falling edge.
                    if (!run) begin
                        stop_req_d = 1'b1;
                    end
                    if (wrap_c) begin
                        cnt_d     = '0;
                        clk_out_d = !clk_out_q;
                        if (!clk_out_q) begin
                            tick_d = 1'b1;
                            if (state_q == ST_PEND) begin
                                active_half_d = pending_q;
                                state_d       = ST_RUN;
                            end
                        end else if (stop_req_q || !run) begin
                            state_d    = ST_STOP;
                            stop_req_d = 1'b0;
                            if (state_q == ST_PEND) begin
                                active_half_d = pending_q;
                            end else if (accept_ok_c) begin
                                active_half_d = cfg_half;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // A request accepted while running waits for the next
                    // rising boundary; one coinciding with a rise waits a period.
                    if (accept_ok_c && (state_d != ST_STOP)) begin
                        pending_d = cfg_half;
                        state_d   = ST_PEND;
                    end
                end
            end

            default: begin
                state_d   = ST_STOP;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q       <= ST_STOP;
            cnt_q         <= '0;
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
            active_half_q <= CNT_W'(DEF_HALF);
            pending_q     <= '0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b1;
            err_q         <= 1'b0;
            stop_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            active_half_q <= active_half_d;
            pending_q     <= pending_d;
            busy_q        <= (state_d == ST_PEND);
            ready_q       <= (state_d != ST_PEND);
            err_q         <= err_d;
            stop_req_q    <= stop_req_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign active_half = active_half_q;
    assign busy        = busy_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl. A phase-level model (time left in the
// current clk_out phase, running flag, pending value) predicts every output on
// every cycle; directed scenarios add hand-computed edge-time expectations.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk_in    = 1'b0;
    logic             rst       = 1'b0;
    logic             run       = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_half  = '0;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] active_half;
    logic             busy;
    logic             cfg_err;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(5)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .clk_out     (clk_out),
        .tick        (tick),
        .active_half (active_half),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_en   = 1'b0;
    bit m_on   = 1'b0;   // divider producing a clock
    bit m_clk  = 1'b0;
    bit m_tick = 1'b0;
    bit m_pv   = 1'b0;   // change pending
    bit m_err  = 1'b0;
    bit m_stop = 1'b0;   // stop requested during a high phase
    int m_h    = 5;
    int m_pval = 0;
    int m_left = 0;      // edges until the next clk_out toggle
    bit m_acc, m_good, m_was_pv;

    task automatic model_stop(input bit good, input int h);
        m_on   = 1'b0;
        m_left = 0;
        m_stop = 1'b0;
        if (m_pv) m_h = m_pval;
        else if (good) m_h = h;
        m_pv = 1'b0;
    endtask

    always @(posedge clk_in) begin
        cyc++;
        if (!rst) begin
            m_en = 1'b1; m_on = 1'b0; m_clk = 1'b0; m_tick = 1'b0; m_pv = 1'b0;
            m_err = 1'b0; m_stop = 1'b0; m_h = 5; m_pval = 0; m_left = 0;
        end else if (m_en) begin
            m_acc    = cfg_valid && !m_pv;
            m_good   = m_acc && (cfg_half != 0);
            m_err    = m_acc && (cfg_half == 0);
            m_tick   = 1'b0;
            m_was_pv = m_pv;
            if (!m_on) begin
                if (m_good) m_h = int'(cfg_half);
                if (run) begin
                    m_on   = 1'b1;
                    m_left = m_h;
                end
            end else if (!run && !m_clk) begin
                model_stop(m_good, int'(cfg_half));
            end else begin
                if (!run) m_stop = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    m_clk = !m_clk;
                    if (m_clk) begin
                        m_tick = 1'b1;
                        if (m_pv) begin
                            m_h  = m_pval;
                            m_pv = 1'b0;
                        end
                        m_left = m_h;
                    end else if (m_stop) begin
                        model_stop(m_good, int'(cfg_half));
                    end else begin
                        m_left = m_h;
                    end
                end
                if (m_on && m_good && !m_was_pv) begin
                    m_pv   = 1'b1;
                    m_pval = int'(cfg_half);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (m_en) begin
            chk("clk_out",     32'(clk_out),     32'(m_clk));
            chk("tick",        32'(tick),        32'(m_tick));
            chk("active_half", 32'(active_half), 32'(m_h));
            chk("busy",        32'(busy),        32'(m_pv));
            chk("cfg_ready",   32'(cfg_ready),   32'(!m_pv));
            chk("cfg_err",     32'(cfg_err),     32'(m_err));
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_tick(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (tick === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            nchk++; nerr++;
            $display("FAIL wait_tick at cycle %0d: got no tick expected one within 100 cycles", cyc);
            c = cyc;
        end
    endtask

    task automatic wait_low(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (clk_out === 1'b0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            nchk++; nerr++;
            $display("FAIL wait_low at cycle %0d: got clk_out high expected low within 100 cycles", cyc);
            c = cyc;
        end
    endtask

    task automatic count_ticks(input int n, output int t);
        t = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (tick === 1'b1 || clk_out === 1'b1) t++;
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_clk_out"},     32'(clk_out),     0);
        chk({nm, "_tick"},        32'(tick),        0);
        chk({nm, "_active_half"}, 32'(active_half), 5);
        chk({nm, "_busy"},        32'(busy),        0);
        chk({nm, "_cfg_ready"},   32'(cfg_ready),   1);
        chk({nm, "_cfg_err"},     32'(cfg_err),     0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int k, r, r2, rp, t;

        // Reset and default ratio.
        repeat (2) @(negedge clk_in);
        chk_reset_vals("rst");
        rst = 1'b1;
        run = 1'b1;
        k   = cyc + 1;
        wait_tick(r);  chk("def_rise1", 32'(r - k), 5);
        wait_tick(r);  chk("def_rise2", 32'(r - k), 15);
        wait_tick(r);  chk("def_rise3", 32'(r - k), 25);
        chk("def_half", 32'(active_half), 5);

        // Reconfigure to H=2 during the high phase.
        cfg_valid = 1'b1; cfg_half = 16'd2;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("cfg_ready_pend", 32'(cfg_ready), 0);
        chk("busy_pend",      32'(busy),      1);
        rp = r;
        wait_tick(r);  chk("recfg_last_period", 32'(r - rp), 10);
        chk("recfg_half",  32'(active_half), 2);
        chk("recfg_ready", 32'(cfg_ready),   1);
        rp = r; wait_tick(r);  chk("recfg_period1", 32'(r - rp), 4);
        rp = r; wait_tick(r);  chk("recfg_period2", 32'(r - rp), 4);

        // Back to H=5.
        cfg_valid = 1'b1; cfg_half = 16'd5;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        rp = r; wait_tick(r);  chk("back5_boundary", 32'(r - rp), 4);
        chk("back5_half", 32'(active_half), 5);
        rp = r; wait_tick(r);  chk("back5_period", 32'(r - rp), 10);

        // Clean stop: run dropped mid high phase, high phase still lasts 5.
        repeat (2) @(negedge clk_in);
        run = 1'b0;
        rp  = r;
        wait_low(t);   chk("stop_high_len", 32'(t - rp), 5);
        count_ticks(20, t);  chk("stop_quiet", 32'(t), 0);

        // Run re-asserted while the high phase completes is ignored until STOP.
        run = 1'b1;
        k   = cyc + 1;
        wait_tick(r);  chk("restart_rise", 32'(r - k), 5);
        @(negedge clk_in); run = 1'b0;
        @(negedge clk_in); run = 1'b1;
        rp = r;
        wait_tick(r);  chk("reassert_delay", 32'(r - rp), 11);

        // Drop run during the low phase: stops with no further rise.
        repeat (6) @(negedge clk_in);
        run = 1'b0;
        count_ticks(20, t);  chk("low_stop_quiet", 32'(t), 0);

        // Zero request while running.
        run = 1'b1;
        k   = cyc + 1;
        wait_tick(r);  chk("zero_start", 32'(r - k), 5);
        cfg_valid = 1'b1; cfg_half = 16'd0;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("zero_err",   32'(cfg_err),   1);
        chk("zero_ready", 32'(cfg_ready), 1);
        chk("zero_busy",  32'(busy),      0);
        @(negedge clk_in);
        chk("zero_err_pulse", 32'(cfg_err),     0);
        chk("zero_half",      32'(active_half), 5);
        rp = r; wait_tick(r);  chk("zero_period", 32'(r - rp), 10);

        // Minimum ratio H=1 loaded in STOP.
        run = 1'b0;
        rp  = r;
        wait_low(t);   chk("min_stop_fall", 32'(t - rp), 5);
        cfg_valid = 1'b1; cfg_half = 16'd1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("min_half",  32'(active_half), 1);
        chk("min_ready", 32'(cfg_ready),   1);
        run = 1'b1;
        k   = cyc + 1;
        wait_tick(r);  chk("min_rise1", 32'(r - k), 1);
        wait_tick(r2); chk("min_period", 32'(r2 - r), 2);

        // Reset while a change to H=8 is pending.
        cfg_valid = 1'b1; cfg_half = 16'd8;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("rp_busy",  32'(busy),      1);
        chk("rp_ready", 32'(cfg_ready), 0);
        rst = 1'b0;
        @(negedge clk_in);
        chk_reset_vals("rst_pend");
        rst = 1'b1;
        k   = cyc + 1;
        wait_tick(r);  chk("rp_rise1", 32'(r - k), 5);
        rp = r; wait_tick(r);  chk("rp_period", 32'(r - rp), 10);
        chk("rp_half", 32'(active_half), 5);

        run = 1'b0;
        repeat (12) @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
        $fatal(1);
    end

endmodule
